// File: rtl/disto_nxn_if.sv
// Request/result bundle for the weighted-Hadamard block distortion engine.
// The requester drives start and the two pixel blocks; the engine returns busy/sum/done.
interface disto_nxn_if #(
   parameter int BLOCK_SIZE = 16,
   parameter int SUM_W      = 32
);
   localparam int PIX_W = 8 * BLOCK_SIZE * BLOCK_SIZE;

   logic             start;
   logic [PIX_W-1:0] ina;
   logic [PIX_W-1:0] inb;
   logic [255:0]     w;
   logic             busy;
   logic [SUM_W-1:0] sum;
   logic             done;

   modport master (output start, ina, inb, w, input busy, sum, done);
   modport slave  (input start, ina, inb, w, output busy, sum, done);
endinterface

// File: rtl/disto_nxn.sv
// Block distortion: one 4x4 sub-block per cycle through a Hadamard transform and weighting,
// followed by an absolute-difference accumulate stage one cycle later.
module disto_nxn #(
   parameter int BLOCK_SIZE = 16,
   parameter int DSHIFT     = 5,
   parameter int SUM_W      = 32
) (
   input logic        clk,
   input logic        rst,
   disto_nxn_if.slave bus
);
   localparam int SB    = BLOCK_SIZE / 4;
   localparam int NB    = SB * SB;
   localparam int S_W   = (NB > 1) ? $clog2(NB) : 1;
   localparam int PIX_W = 8 * BLOCK_SIZE * BLOCK_SIZE;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t             state;
   logic [PIX_W-1:0]   a_lat, b_lat;
   logic [255:0]       w_lat;
   logic [S_W-1:0]     s;
   logic [31:0]        t_a, t_b;
   logic               vld1;
   logic [SUM_W-1:0]   acc, sum_r;
   logic               busy_r, done_r;
   logic [127:0]       blk_a, blk_b;
   logic signed [32:0] diff;
   logic [32:0]        mag33;
   logic [31:0]        d;
   logic [SUM_W-1:0]   acc_nxt;

   // Row pass then column pass of the 4-point Hadamard, then sum of w[k]*|c[k]|.
   function automatic logic [31:0] wsum(input logic [127:0] blk, input logic [255:0] wt);
      logic signed [15:0] m [4][4];
      logic signed [15:0] c [4][4];
      logic signed [15:0] p0, p1, p2, p3, a0, a1, a2, a3;
      logic [15:0]        mag;
      logic [31:0]        t;
      t = '0;
      for (int v = 0; v < 4; v++) begin
         p0 = $signed({8'd0, blk[8*(v*4+0) +: 8]});
         p1 = $signed({8'd0, blk[8*(v*4+1) +: 8]});
         p2 = $signed({8'd0, blk[8*(v*4+2) +: 8]});
         p3 = $signed({8'd0, blk[8*(v*4+3) +: 8]});
         a0 = p0 + p2; a1 = p1 + p3; a2 = p1 - p3; a3 = p0 - p2;
         m[v][0] = a0 + a1; m[v][1] = a3 + a2; m[v][2] = a3 - a2; m[v][3] = a0 - a1;
      end
      for (int u = 0; u < 4; u++) begin
         p0 = m[0][u]; p1 = m[1][u]; p2 = m[2][u]; p3 = m[3][u];
         a0 = p0 + p2; a1 = p1 + p3; a2 = p1 - p3; a3 = p0 - p2;
         c[0][u] = a0 + a1; c[1][u] = a3 + a2; c[2][u] = a3 - a2; c[3][u] = a0 - a1;
      end
      for (int v = 0; v < 4; v++) begin
         for (int u = 0; u < 4; u++) begin
            mag = c[v][u][15] ? 16'(-c[v][u]) : 16'(c[v][u]);
            t   = t + 32'(wt[16*(v*4+u) +: 16]) * 32'(mag);
         end
      end
      return t;
   endfunction

   // Gather sub-block s (raster order) from both latched blocks.
   always_comb begin
      int bx, by, base;
      blk_a = '0;
      blk_b = '0;
      bx = int'(s) % SB;
      by = int'(s) / SB;
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 4; i++) begin
            base = 8 * ((by*4 + j) * BLOCK_SIZE + bx*4 + i);
            blk_a[8*(j*4+i) +: 8] = a_lat[base +: 8];
            blk_b[8*(j*4+i) +: 8] = b_lat[base +: 8];
         end
      end
   end

   always_comb begin
      diff    = $signed({1'b0, t_b}) - $signed({1'b0, t_a});
      mag33   = diff[32] ? 33'(-diff) : 33'(diff);
      d       = mag33[31:0] >> DSHIFT;
      acc_nxt = acc + SUM_W'(d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_lat  <= '0;
         b_lat  <= '0;
         w_lat  <= '0;
         s      <= '0;
         t_a    <= '0;
         t_b    <= '0;
         vld1   <= 1'b0;
         acc    <= '0;
         sum_r  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_lat  <= bus.ina;
                  b_lat  <= bus.inb;
                  w_lat  <= bus.w;
                  acc    <= '0;
                  s      <= '0;
                  vld1   <= 1'b0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               t_a  <= wsum(blk_a, w_lat);
               t_b  <= wsum(blk_b, w_lat);
               vld1 <= 1'b1;
               // First RUN cycle has no stage-1 result yet.
               if (vld1) acc <= acc_nxt;
               if (s == S_W'(NB - 1)) begin
                  s     <= '0;
                  state <= FLUSH;
               end else begin
                  s <= s + 1'b1;
               end
            end
            FLUSH: begin
               acc    <= acc_nxt;
               sum_r  <= acc_nxt;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               vld1   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.sum  = sum_r;
endmodule

// File: tb/tb_disto_nxn.sv
// Bench for disto_nxn: three block sizes side by side, checked against a matrix-form
// Hadamard reference computed directly from the pixel arrays.
module tb_disto_nxn;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   disto_nxn_if #(.BLOCK_SIZE(16), .SUM_W(32)) if16 ();
   disto_nxn_if #(.BLOCK_SIZE(8),  .SUM_W(16)) if8 ();
   disto_nxn_if #(.BLOCK_SIZE(4),  .SUM_W(16)) if4 ();

   disto_nxn #(.BLOCK_SIZE(16), .DSHIFT(5), .SUM_W(32)) dut16 (.clk(clk), .rst(rst), .bus(if16));
   disto_nxn #(.BLOCK_SIZE(8),  .DSHIFT(5), .SUM_W(16)) dut8  (.clk(clk), .rst(rst), .bus(if8));
   disto_nxn #(.BLOCK_SIZE(4),  .DSHIFT(5), .SUM_W(16)) dut4  (.clk(clk), .rst(rst), .bus(if4));

   logic [7:0]    pa [256];
   logic [7:0]    pb [256];
   logic [15:0]   wt [16];
   logic [2047:0] pa_v, pb_v;
   logic [255:0]  w_v;
   logic [2:0]    st, dn, bz;
   logic [31:0]   sm [3];
   int            n_chk = 0;
   int            n_fail = 0;
   int            H [4][4];
   int            BSZ [3] = '{16, 8, 4};
   int            SWD [3] = '{32, 16, 16};
   longint        last;

   always_comb begin
      pa_v = '0; pb_v = '0; w_v = '0;
      for (int i = 0; i < 256; i++) begin
         pa_v[8*i +: 8] = pa[i];
         pb_v[8*i +: 8] = pb[i];
      end
      for (int k = 0; k < 16; k++) w_v[16*k +: 16] = wt[k];
   end

   assign if16.start = st[0]; assign if16.ina = pa_v;          assign if16.inb = pb_v;          assign if16.w = w_v;
   assign if8.start  = st[1]; assign if8.ina  = pa_v[511:0];   assign if8.inb  = pb_v[511:0];   assign if8.w  = w_v;
   assign if4.start  = st[2]; assign if4.ina  = pa_v[127:0];   assign if4.inb  = pb_v[127:0];   assign if4.w  = w_v;
   assign dn = {if4.done, if8.done, if16.done};
   assign bz = {if4.busy, if8.busy, if16.busy};
   assign sm[0] = if16.sum;
   assign sm[1] = {16'd0, if8.sum};
   assign sm[2] = {16'd0, if4.sum};

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // C = H * P * H^T per 4x4 sub-block, T = sum w*|C|.
   function automatic longint tsub(input bit is_b, input int bs, input int bx, input int by);
      longint t, c, px;
      t = 0;
      for (int v = 0; v < 4; v++)
         for (int u = 0; u < 4; u++) begin
            c = 0;
            for (int j = 0; j < 4; j++)
               for (int i = 0; i < 4; i++) begin
                  px = is_b ? longint'(pb[(by*4+j)*bs + bx*4 + i]) : longint'(pa[(by*4+j)*bs + bx*4 + i]);
                  c += longint'(H[v][j] * H[u][i]) * px;
               end
            t += longint'(wt[v*4+u]) * (c < 0 ? -c : c);
         end
      return t & 64'hFFFF_FFFF;
   endfunction

   function automatic longint model(input int bs, input int sw);
      longint acc, ta, tb, dd;
      acc = 0;
      for (int by = 0; by < bs/4; by++)
         for (int bx = 0; bx < bs/4; bx++) begin
            ta  = tsub(1'b0, bs, bx, by);
            tb  = tsub(1'b1, bs, bx, by);
            dd  = (ta > tb ? ta - tb : tb - ta) >> 5;
            acc = (acc + dd) & ((longint'(1) << sw) - 1);
         end
      return acc;
   endfunction

   task automatic fill(input int a, input int b, input int wv);
      for (int i = 0; i < 256; i++) begin pa[i] = 8'(a); pb[i] = 8'(b); end
      for (int k = 0; k < 16; k++) wt[k] = 16'(wv);
   endtask

   task automatic rnd();
      for (int i = 0; i < 256; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
      for (int k = 0; k < 16; k++) wt[k] = 16'($urandom);
   endtask

   task automatic wait_done(input int sel, input int n0, output int n);
      n = n0;
      while (dn[sel] !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that raised done.
   task automatic run_op(input int sel, input string tag);
      longint e;
      int     n;
      e = model(BSZ[sel], SWD[sel]);
      st[sel] = 1'b1;
      @(posedge clk); #1;
      st[sel] = 1'b0;
      wait_done(sel, 0, n);
      chk({tag, " latency"}, n, BSZ[sel]*BSZ[sel]/16 + 1);
      chk({tag, " sum"}, sm[sel], e);
      last = sm[sel];
   endtask

   initial begin
      longint e1, e2, r1;
      int     n, dc;
      logic [7:0] tmp;
      H[0] = '{1, 1, 1, 1};
      H[1] = '{1, 1, -1, -1};
      H[2] = '{1, -1, -1, 1};
      H[3] = '{1, -1, 1, -1};
      st = '0;
      rst = 1'b1;
      fill(0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset busy %0d", k), bz[k], 0);
         chk($sformatf("reset done %0d", k), dn[k], 0);
         chk($sformatf("reset sum %0d", k), sm[k], 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      fill(0, 255, 1);  run_op(0, "flat16");  chk("flat16 const", last, 2032);
      fill(255, 0, 1);  run_op(0, "swap16");  chk("swap16 const", last, 2032);
      rnd();
      for (int i = 0; i < 256; i++) pb[i] = pa[i];
      run_op(0, "same16"); chk("same16 zero", last, 0);

      rnd(); run_op(0, "sym_ab"); r1 = last;
      for (int i = 0; i < 256; i++) begin tmp = pa[i]; pa[i] = pb[i]; pb[i] = tmp; end
      run_op(0, "sym_ba"); chk("symmetry", last, r1);

      fill(0, 10, 0); wt[0] = 16'd2;
      run_op(2, "w0_bs4"); chk("w0_bs4 const", last, 10);

      // Start while busy is dropped; start on the done cycle is taken.
      rnd(); e1 = model(16, 32);
      st[0] = 1'b1; @(posedge clk); #1; st[0] = 1'b0;
      chk("b2b busy", bz[0], 1);
      repeat (4) begin @(posedge clk); #1; end
      rnd(); e2 = model(16, 32);
      st[0] = 1'b1; @(posedge clk); #1; st[0] = 1'b0;
      wait_done(0, 5, n);
      chk("ignored latency", n, 17);
      chk("ignored sum", sm[0], e1);
      st[0] = 1'b1; @(posedge clk); #1; st[0] = 1'b0;
      chk("held sum", sm[0], e1);
      chk("second busy", bz[0], 1);
      wait_done(0, 0, n);
      chk("second latency", n, 17);
      chk("second sum", sm[0], e2);

      // Abort mid-RUN with an asynchronous reset.
      rnd();
      st[0] = 1'b1; @(posedge clk); #1; st[0] = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("abort busy", bz[0], 0);
      chk("abort done", dn[0], 0);
      chk("abort sum", sm[0], 0);
      dc = 0;
      repeat (3) begin @(posedge clk); #1; if (dn[0]) dc++; end
      rst = 1'b0;
      repeat (20) begin @(posedge clk); #1; if (dn[0]) dc++; end
      chk("abort no done", dc, 0);
      rnd(); run_op(0, "after_rst");

      for (int sel = 0; sel < 3; sel++)
         for (int t = 0; t < 1000; t++) begin
            rnd();
            run_op(sel, $sformatf("rand bs%0d #%0d", BSZ[sel], t));
         end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/disto_nxn.md
DISTO_NXN -- requirements
Module: disto_nxn

Interface
REQ-001 Parameter BLOCK_SIZE, default 16, block edge in pixels; legal values 4, 8, 16.
REQ-002 Parameter DSHIFT, default 5, right shift applied to each 4x4 sub-block distortion.
REQ-003 Parameter SUM_W, default 32, width of sum output and accumulator.
REQ-004 One clock; reset is asynchronous and active-high. Ports: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request pulse, sampled only in IDLE.
REQ-006 ina  input  8*BLOCK_SIZE^2  block A, unsigned 8-bit pixels; pixel (x,y) at bits [8*(y*BLOCK_SIZE+x) +: 8].
REQ-007 inb  input  8*BLOCK_SIZE^2  block B, same packing as ina.
REQ-008 w  input  256  sixteen unsigned 16-bit weights; weight k=v*4+u at bits [16*k +: 16], shared by all sub-blocks.
REQ-009 busy  output  1  high in RUN and FLUSH.
REQ-010 sum  output  SUM_W  distortion result, held until the next done.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 NB = (BLOCK_SIZE/4)^2 sub-blocks shall be processed in raster order: sub-block index s = by*(BLOCK_SIZE/4)+bx.
REQ-013 At the edge sampling start=1 in IDLE: ina, inb and w are latched internally, the accumulator and s are cleared to 0, and the state moves to RUN. Later input changes shall not affect the result.
REQ-014 States: IDLE -> RUN on start; RUN -> FLUSH after the edge issuing s=NB-1; FLUSH -> IDLE after one cycle. There are no other transitions except reset.
REQ-015 Each RUN cycle shall compute the transform for sub-block s of both A and B with one shared 4x4 datapath per block, register the two weighted sums (stage 1), and increment s.
REQ-016 Transform per row, then per column: a0=p0+p2, a1=p1+p3, a2=p1-p3, a3=p0-p2; out0=a0+a1, out1=a3+a2, out2=a3-a2, out3=a0-a1. Use signed arithmetic of at least 13 bits.
REQ-017 Weighted sum T = sum over k of w[k]*|c[k]|, where c[k] is the transform coefficient at (u,v); T is unsigned 32-bit.
REQ-018 Stage 2, one cycle after stage 1: d = |T_B - T_A| >> DSHIFT, computed as a signed 33-bit difference. acc <= acc + d, wrapping modulo 2^SUM_W with no saturation.
REQ-019 At the FLUSH edge: the last d is accumulated, sum <= final acc, and done <= 1 for exactly one cycle. Done therefore rises NB+1 rising edges after the edge that sampled start (17 for BLOCK_SIZE=16; 2 for BLOCK_SIZE=4).
REQ-020 start while busy=1 shall be ignored, with no restart and no queuing.
REQ-021 start on the cycle where done=1 (state IDLE) shall be accepted, giving back-to-back operation. The sum from the previous operation stays held until the new done.
REQ-022 The result shall be symmetric: swapping ina and inb yields the identical sum.

Reset
REQ-023 When rst is asserted (asynchronously, any state including mid-RUN): state=IDLE, busy=0, done=0, sum=0, accumulator=0, s=0, and stage registers=0.
REQ-024 An operation aborted by reset shall never assert done. The first start after rst deasserts behaves as a fresh operation.

Verification
REQ-025 BLOCK_SIZE=16, DSHIFT=5, w all 1, ina=all 0, inb=all 255, start pulse -> done exactly 17 cycles later, sum=2032 (16 sub-blocks x (4080>>5)=127).
REQ-026 Same stimulus with ina and inb swapped -> sum=2032; ina==inb with random data and random w -> sum=0.
REQ-027 BLOCK_SIZE=4, w[0]=2 and others 0, ina=all 0, inb=all 10 -> done 2 cycles after start, sum=(2*160)>>5=10.
REQ-028 A start pulse at the 5th busy cycle, followed by a start pulse on the done cycle -> the first is ignored, the second is accepted; the second result matches the reference model and is delivered 17 cycles after its start.
REQ-029 rst asserted mid-RUN -> busy, done and sum drop to 0 immediately, with no done pulse. A fresh start then yields the correct sum.
REQ-030 Randomized: 1000 operations per legal BLOCK_SIZE with random pixels and random weights -> sum bit-exact against a C model of REQ-016 to REQ-018, including wrap at SUM_W=16.
